request_unit: RTL and testbench

Memory request sequencer between the single-cycle datapath and the memory arbiter/cache. It holds the instruction-fetch request while instructions are fetched. For each load or store, it raises and holds one data request until the memory acknowledges it. It also latches the processor halt. A watchdog flags a data request that is never acknowledged.

---
 rtl/request_unit.sv | 124 ++++++++++++
 tb/tb_request_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/request_unit.sv
// request_unit: sequences instruction-fetch and data-memory requests for a
// single-cycle core, latches the halt and flags data requests that never
// receive an acknowledge.
//
// Handshake: a data request (dmemREN or dmemWEN) is raised on the edge after
// the accepting ihit and is held stable every cycle until dhit is sampled
// high. On that edge it drops. dhit in any other state is ignored.
module request_unit #(
    parameter int MAX_WAIT = 255
) (
    input  logic                               CLK,
    input  logic                               nRST,
    input  logic                               ihit,
    input  logic                               dhit,
    input  logic                               dmemREN_req,
    input  logic                               dmemWEN_req,
    input  logic                               halt,
    output logic                               imemREN,
    output logic                               dmemREN,
    output logic                               dmemWEN,
    output logic                               halted,
    output logic                               timeout,
    output logic [1:0]                         dbg_state,
    output logic [$clog2(MAX_WAIT+1)-1:0]      dbg_wcnt
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WCNT_MAX = CW'(MAX_WAIT);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2,
        ERR    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wcnt_q, wcnt_d;
    logic            dmem_ren_q, dmem_ren_d;
    logic            dmem_wen_q, dmem_wen_d;
    logic            halted_q, halted_d;
    logic            timeout_q, timeout_d;

    // State, watchdog counter and registered outputs; reset returns to RUN.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= RUN;
            wcnt_q     <= '0;
            dmem_ren_q <= 1'b0;
            dmem_wen_q <= 1'b0;
            halted_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            dmem_ren_q <= dmem_ren_d;
            dmem_wen_q <= dmem_wen_d;
            halted_q   <= halted_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state logic: halt beats a data request, dhit beats the watchdog.
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        dmem_ren_d = dmem_ren_q;
        dmem_wen_d = dmem_wen_q;
        halted_d   = halted_q;
        timeout_d  = timeout_q;
        case (state_q)
            RUN: begin
                if (ihit) begin
                    if (halt) begin
                        state_d  = HALTED;
                        halted_d = 1'b1;
                    end else if (dmemREN_req || dmemWEN_req) begin
                        state_d    = DWAIT;
                        wcnt_d     = '0;
                        // A read and a write together: the read is issued alone.
                        dmem_ren_d = dmemREN_req;
                        dmem_wen_d = dmemWEN_req & ~dmemREN_req;
                    end
                end
            end
            DWAIT: begin
                if (dhit) begin
                    state_d    = RUN;
                    dmem_ren_d = 1'b0;
                    dmem_wen_d = 1'b0;
                end else if (wcnt_q == WCNT_MAX) begin
                    state_d    = ERR;
                    dmem_ren_d = 1'b0;
                    dmem_wen_d = 1'b0;
                    halted_d   = 1'b1;
                    timeout_d  = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + CW'(1);
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Outputs come only from flops or a decode of the state register.
    always_comb begin
        imemREN   = (state_q == RUN);
        dmemREN   = dmem_ren_q;
        dmemWEN   = dmem_wen_q;
        halted    = halted_q;
        timeout   = timeout_q;
        dbg_state = state_q;
        dbg_wcnt  = wcnt_q;
    end

endmodule

// File: tb/tb_request_unit.sv
// Directed bench for request_unit with a small behavioural model of the
// request sequencer checked against the DUT on every falling edge.
module tb_request_unit;

  localparam int MW = 4;
  localparam int CW = $clog2(MW + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  logic ihit = 1'b0, dhit = 1'b0, rreq = 1'b0, wreq = 1'b0, halt_in = 1'b0;
  logic imem_ren, dmem_ren, dmem_wen, halted, timeout;
  logic [1:0] dbg_state;
  logic [CW-1:0] dbg_wcnt;

  request_unit #(.MAX_WAIT(MW)) dut (
    .CLK(clk), .nRST(n_rst), .ihit(ihit), .dhit(dhit),
    .dmemREN_req(rreq), .dmemWEN_req(wreq), .halt(halt_in),
    .imemREN(imem_ren), .dmemREN(dmem_ren), .dmemWEN(dmem_wen),
    .halted(halted), .timeout(timeout),
    .dbg_state(dbg_state), .dbg_wcnt(dbg_wcnt)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // An access is "pending" from the edge after the accepting ihit until dhit;
  // its age is the number of whole wait cycles already spent without dhit.
  logic m_busy, m_rd, m_wr, m_halted, m_timeout;
  int   m_age;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_busy <= 1'b0; m_rd <= 1'b0; m_wr <= 1'b0;
      m_halted <= 1'b0; m_timeout <= 1'b0; m_age <= 0;
    end else if (m_halted) begin
      m_busy <= 1'b0;
    end else if (!m_busy) begin
      if (ihit && halt_in) begin
        m_halted <= 1'b1;
      end else if (ihit && (rreq || wreq)) begin
        m_busy <= 1'b1;
        m_rd   <= rreq;
        m_wr   <= wreq && !rreq;
        m_age  <= 0;
      end
    end else if (dhit) begin
      m_busy <= 1'b0; m_rd <= 1'b0; m_wr <= 1'b0;
    end else if (m_age == MW) begin
      m_busy <= 1'b0; m_rd <= 1'b0; m_wr <= 1'b0;
      m_halted <= 1'b1; m_timeout <= 1'b1;
    end else begin
      m_age <= m_age + 1;
    end
  end

  // ---------------- scoreboard compare ----------------
  logic [31:0] exp_q[$];
  always @(negedge clk) begin
    exp_q.delete();
    exp_q.push_back(32'(!m_busy && !m_halted));
    exp_q.push_back(32'(m_rd));
    exp_q.push_back(32'(m_wr));
    exp_q.push_back(32'(m_halted));
    exp_q.push_back(32'(m_timeout));
    exp_q.push_back(m_timeout ? 32'd3 : m_halted ? 32'd2 : m_busy ? 32'd1 : 32'd0);
    chk("model_imemREN", 32'(imem_ren), exp_q[0]);
    chk("model_dmemREN", 32'(dmem_ren), exp_q[1]);
    chk("model_dmemWEN", 32'(dmem_wen), exp_q[2]);
    chk("model_halted", 32'(halted), exp_q[3]);
    chk("model_timeout", 32'(timeout), exp_q[4]);
    chk("model_state", 32'(dbg_state), exp_q[5]);
    if (m_busy) chk("model_wcnt", 32'(dbg_wcnt), 32'(m_age));
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic r, input logic w, input logic h);
    tick();
    ihit = 1'b1; rreq = r; wreq = w; halt_in = h;
    tick();
    ihit = 1'b0; rreq = 1'b0; wreq = 1'b0; halt_in = 1'b0;
  endtask

  task automatic do_reset;
    tick();
    n_rst = 1'b0;
    tick();
    tick();
    n_rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    // Reset then idle for 10 cycles.
    tick();
    tick();
    n_rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      chk("idle_imemREN", 32'(imem_ren), 32'd1);
      chk("idle_state", 32'(dbg_state), 32'd0);
    end

    // Load: dhit arrives in the third DWAIT cycle.
    issue(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) tick();
      if (c == 3) dhit = 1'b1;
      @(negedge clk);
      chk("load_dmemREN", 32'(dmem_ren), 32'd1);
      chk("load_imemREN", 32'(imem_ren), 32'd0);
    end
    tick();
    dhit = 1'b0;
    @(negedge clk);
    chk("load_done_dmemREN", 32'(dmem_ren), 32'd0);
    chk("load_done_imemREN", 32'(imem_ren), 32'd1);

    // Store acknowledged on the first DWAIT cycle.
    issue(1'b0, 1'b1, 1'b0);
    dhit = 1'b1;
    @(negedge clk);
    chk("store_dmemWEN", 32'(dmem_wen), 32'd1);
    tick();
    dhit = 1'b0;
    @(negedge clk);
    chk("store_done_dmemWEN", 32'(dmem_wen), 32'd0);
    chk("store_done_imemREN", 32'(imem_ren), 32'd1);

    // Both requests: read wins.
    issue(1'b1, 1'b1, 1'b0);
    dhit = 1'b1;
    @(negedge clk);
    chk("both_dmemREN", 32'(dmem_ren), 32'd1);
    chk("both_dmemWEN", 32'(dmem_wen), 32'd0);
    tick();
    dhit = 1'b0;

    // Watchdog boundary: dhit on the fifth (last) DWAIT cycle still wins.
    issue(1'b1, 1'b0, 1'b0);
    for (int c = 2; c <= 5; c++) tick();
    dhit = 1'b1;
    @(negedge clk);
    chk("edge_wcnt", 32'(dbg_wcnt), 32'd4);
    tick();
    dhit = 1'b0;
    @(negedge clk);
    chk("edge_state", 32'(dbg_state), 32'd0);
    chk("edge_timeout", 32'(timeout), 32'd0);

    // Reset in the middle of a load drops the request asynchronously.
    issue(1'b1, 1'b0, 1'b0);
    tick();
    #2;
    chk("pre_rst_dmemREN", 32'(dmem_ren), 32'd1);
    n_rst = 1'b0;
    #1;
    chk("async_rst_dmemREN", 32'(dmem_ren), 32'd0);
    chk("async_rst_imemREN", 32'(imem_ren), 32'd1);
    tick();
    tick();
    n_rst = 1'b1;
    @(negedge clk);
    chk("post_rst_state", 32'(dbg_state), 32'd0);
    chk("post_rst_wcnt", 32'(dbg_wcnt), 32'd0);

    // Watchdog expiry: no dhit during all five DWAIT cycles.
    issue(1'b1, 1'b0, 1'b0);
    for (int c = 2; c <= 5; c++) tick();
    @(negedge clk);
    chk("wd_last_timeout", 32'(timeout), 32'd0);
    tick();
    @(negedge clk);
    chk("wd_timeout", 32'(timeout), 32'd1);
    chk("wd_halted", 32'(halted), 32'd1);
    chk("wd_dmemREN", 32'(dmem_ren), 32'd0);

    // Halt beats a store request and is absorbing.
    do_reset();
    issue(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_imemREN", 32'(imem_ren), 32'd0);
    chk("halt_dmemWEN", 32'(dmem_wen), 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      ihit = 1'($urandom_range(0, 1));
      dhit = 1'($urandom_range(0, 1));
      rreq = 1'($urandom_range(0, 1));
      wreq = 1'($urandom_range(0, 1));
    end
    tick();
    ihit = 1'b0; dhit = 1'b0; rreq = 1'b0; wreq = 1'b0;
    @(negedge clk);
    chk("halt_sticky", 32'(halted), 32'd1);
    chk("halt_no_timeout", 32'(timeout), 32'd0);
    chk("halt_state", 32'(dbg_state), 32'd2);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
